// File: rtl/vscale_htif_host.sv
// vscale_htif_host: host-side HTIF engine issuing user PCR commands and polling tohost
module vscale_htif_host #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 64,
  parameter int TIMEOUT = 1024,
  parameter int POLL_INTERVAL = 256,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR = 12'h780
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_err,
  input  logic              poll_en,
  output logic              tohost_valid,
  input  logic              tohost_ready,
  output logic [DATA_W-1:0] tohost_data,
  output logic              pcr_req_valid,
  input  logic              pcr_req_ready,
  output logic              pcr_req_rw,
  output logic [ADDR_W-1:0] pcr_req_addr,
  output logic [DATA_W-1:0] pcr_req_data,
  input  logic              pcr_resp_valid,
  output logic              pcr_resp_ready,
  input  logic [DATA_W-1:0] pcr_resp_data,
  output logic              busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2(POLL_INTERVAL + 1);
  typedef enum logic [1:0] {IDLE, REQ, RESP, RESULT} state_e;
  typedef enum logic [1:0] {USER, POLL, CLEAR} tag_e;
  state_e state_q, state_d;
  tag_e tag_q, tag_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] poll_q, poll_d;
  logic pend_q, pend_d;
  logic rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic res_err_q, res_err_d;
  logic th_valid_q, th_valid_d;
  logic [DATA_W-1:0] th_data_q, th_data_d;
  logic active, tmo_hit, done, fail, due;
  assign active = state_q == REQ || state_q == RESP;
  assign tmo_hit = tmo_q == TW'(TIMEOUT - 1);
  assign done = state_q == RESP && pcr_resp_valid;
  assign fail = active && tmo_hit && !done;
  assign due = poll_en && !th_valid_q && (pend_q || (state_q == IDLE && poll_q == PW'(POLL_INTERVAL - 1)));
  assign cmd_ready = state_q == IDLE;
  assign busy = state_q != IDLE;
  assign res_valid = state_q == RESULT;
  assign res_data = res_data_q;
  assign res_err = res_err_q;
  assign tohost_valid = th_valid_q;
  assign tohost_data = th_data_q;
  assign pcr_req_valid = state_q == REQ && !tmo_hit;
  assign pcr_req_rw = rw_q;
  assign pcr_req_addr = addr_q;
  assign pcr_req_data = data_q;
  assign pcr_resp_ready = state_q == IDLE || state_q == RESP;
  always_comb begin
    state_d = state_q;
    tag_d = tag_q;
    tmo_d = active ? tmo_q + TW'(1) : '0;
    poll_d = (state_q == IDLE && poll_en && !th_valid_q) ? poll_q + PW'(1) : '0;
    pend_d = pend_q && poll_en;
    rw_d = rw_q;
    addr_d = addr_q;
    data_d = data_q;
    res_data_d = res_data_q;
    res_err_d = res_err_q;
    th_valid_d = th_valid_q && !tohost_ready;
    th_data_d = th_data_q;
    case (state_q)
      IDLE: if (cmd_valid || due) begin
        state_d = REQ;
        tag_d = cmd_valid ? USER : POLL;
        rw_d = cmd_valid && cmd_rw;
        addr_d = cmd_valid ? cmd_addr : TOHOST_ADDR;
        data_d = cmd_valid ? cmd_data : '0;
        poll_d = '0;
        pend_d = cmd_valid && due;
      end
      REQ: if (!tmo_hit && pcr_req_ready) state_d = RESP;
      RESULT: if (res_ready) state_d = IDLE;
      default: ;
    endcase
    if (fail) begin
      state_d = tag_q == USER ? RESULT : IDLE;
      if (tag_q == USER) begin
        res_data_d = '0;
        res_err_d = 1'b1;
      end
    end
    if (done && tag_q == USER) begin
      state_d = RESULT;
      res_data_d = pcr_resp_data;
      res_err_d = 1'b0;
    end
    if (done && tag_q == POLL) begin
      state_d = IDLE;
      if (pcr_resp_data != '0) begin
        state_d = REQ;
        tag_d = CLEAR;
        rw_d = 1'b1;
        addr_d = TOHOST_ADDR;
        data_d = '0;
        tmo_d = '0;
        th_data_d = pcr_resp_data;
      end
    end
    if (done && tag_q == CLEAR) begin
      state_d = IDLE;
      th_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      tag_q <= USER;
      tmo_q <= '0;
      poll_q <= '0;
      pend_q <= 1'b0;
      rw_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      res_data_q <= '0;
      res_err_q <= 1'b0;
      th_valid_q <= 1'b0;
      th_data_q <= '0;
    end else begin
      state_q <= state_d;
      tag_q <= tag_d;
      tmo_q <= tmo_d;
      poll_q <= poll_d;
      pend_q <= pend_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      data_q <= data_d;
      res_data_q <= res_data_d;
      res_err_q <= res_err_d;
      th_valid_q <= th_valid_d;
      th_data_q <= th_data_d;
    end
  end
endmodule

// File: tb/tb_vscale_htif_host.sv
// tb_vscale_htif_host: vector, random and sequence checks of the HTIF host engine
module tb_vscale_htif_host;
  localparam int TMO = 32;
  localparam int PI = 16;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_rw = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [63:0] cmd_data = '0;
  logic res_valid, res_ready = 1'b0, res_err;
  logic [63:0] res_data;
  logic poll_en = 1'b0, tohost_valid, tohost_ready = 1'b0;
  logic [63:0] tohost_data;
  logic pcr_req_valid, pcr_req_ready = 1'b0, pcr_req_rw;
  logic [11:0] pcr_req_addr;
  logic [63:0] pcr_req_data;
  logic pcr_resp_valid = 1'b0, pcr_resp_ready;
  logic [63:0] pcr_resp_data = '0;
  logic busy;
  int n_chk = 0, n_pass = 0;
  logic [63:0] mem [4096];
  typedef struct {
    logic rw; logic [11:0] a; logic [63:0] d; int rdy; int rsp;
    logic [63:0] rdata; logic err; logic [63:0] edata; int ek;
  } vec_t;
  vec_t tbl [9];
  always #5 clk = ~clk;
  vscale_htif_host #(.ADDR_W(12), .DATA_W(64), .TIMEOUT(TMO), .POLL_INTERVAL(PI), .TOHOST_ADDR(12'h780)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .poll_en(poll_en), .tohost_valid(tohost_valid), .tohost_ready(tohost_ready), .tohost_data(tohost_data),
    .pcr_req_valid(pcr_req_valid), .pcr_req_ready(pcr_req_ready), .pcr_req_rw(pcr_req_rw),
    .pcr_req_addr(pcr_req_addr), .pcr_req_data(pcr_req_data),
    .pcr_resp_valid(pcr_resp_valid), .pcr_resp_ready(pcr_resp_ready), .pcr_resp_data(pcr_resp_data),
    .busy(busy)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic bit completes(input int rdy, input int rsp);
    return rdy <= TMO - 2 && rsp >= 1 && rdy + rsp <= TMO - 1;
  endfunction
  task automatic user_txn(input logic rw, input logic [11:0] a, input logic [63:0] d, input int rdy, input int rsp,
                          input logic [63:0] rdata, input logic exp_err, input logic [63:0] exp_data, input int exp_k);
    int k, h, hs;
    h = -1;
    hs = 0;
    chk("cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("busy", busy, 1);
    k = 0;
    while (!res_valid && k <= TMO + 4) begin
      pcr_resp_valid = h >= 0 && rsp >= 1 && k == h + rsp;
      pcr_resp_data = pcr_resp_valid ? rdata : {$urandom, $urandom};
      pcr_req_ready = h < 0 && k >= rdy;
      if (pcr_req_ready && pcr_req_valid) begin
        hs++;
        h = k;
        chk("req_rw", pcr_req_rw, rw);
        chk("req_addr", pcr_req_addr, a);
        chk("req_data", pcr_req_data, d);
      end
      if (pcr_resp_valid) chk("resp_ready", pcr_resp_ready, 1);
      @(negedge clk);
      k++;
    end
    pcr_req_ready = 1'b0;
    pcr_resp_valid = 1'b0;
    chk("res_valid", res_valid, 1);
    chk("res_latency", k, exp_k);
    chk("res_err", res_err, exp_err);
    chk("res_data", res_data, exp_data);
    chk("req_handshakes", hs, (rdy <= TMO - 2) ? 1 : 0);
    repeat ($urandom_range(0, 3)) begin
      @(negedge clk);
      chk("res_hold_valid", res_valid, 1);
      chk("res_hold_data", res_data, exp_data);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk("res_released", res_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask
  task automatic serve(input string nm, input logic erw, input logic [63:0] ed, input bit cd,
                       input logic [63:0] rd, input int budget, output int w);
    w = 0;
    while (!pcr_req_valid && w < budget) begin
      @(negedge clk);
      w++;
    end
    chk({nm, "_req_valid"}, pcr_req_valid, 1);
    chk({nm, "_rw"}, pcr_req_rw, erw);
    chk({nm, "_addr"}, pcr_req_addr, 12'h780);
    if (cd) chk({nm, "_data"}, pcr_req_data, ed);
    pcr_req_ready = 1'b1;
    @(negedge clk);
    pcr_req_ready = 1'b0;
    pcr_resp_valid = 1'b1;
    pcr_resp_data = rd;
    @(negedge clk);
    pcr_resp_valid = 1'b0;
    chk({nm, "_no_result"}, res_valid, 0);
  endtask
  initial begin
    logic rw;
    logic [11:0] a;
    logic [63:0] d, rdata;
    int rdy, rsp, w, n;
    bit ok;
    for (int i = 0; i < 4096; i++) mem[i] = 64'(i) * 64'h9E37_79B9_7F4A_7C15;
    tbl[0] = '{1'b0, 12'h50D, 64'h0, 2, 3, 64'h1234, 1'b0, 64'h1234, 6};
    tbl[1] = '{1'b0, 12'h001, 64'h0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 2};
    tbl[2] = '{1'b1, 12'h123, 64'hCAFE, 40, 1, 64'h5, 1'b1, 64'h0, TMO};
    tbl[3] = '{1'b0, 12'h234, 64'h0, 0, TMO - 1, 64'h77, 1'b0, 64'h77, TMO};
    tbl[4] = '{1'b0, 12'h235, 64'h0, 0, TMO, 64'h88, 1'b1, 64'h0, TMO};
    tbl[5] = '{1'b0, 12'h236, 64'h0, TMO - 2, 1, 64'h99, 1'b0, 64'h99, TMO};
    tbl[6] = '{1'b1, 12'h237, 64'h1, TMO - 1, 1, 64'hAA, 1'b1, 64'h0, TMO};
    tbl[7] = '{1'b1, 12'hFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1, 2, 64'h0, 1'b0, 64'h0, 4};
    tbl[8] = '{1'b1, 12'h780, 64'hDEAD, 0, 0, 64'h0, 1'b1, 64'h0, TMO};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_err", res_err, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_req_valid", pcr_req_valid, 0);
    chk("rst_req_rw", pcr_req_rw, 0);
    chk("rst_req_addr", pcr_req_addr, 0);
    chk("rst_req_data", pcr_req_data, 0);
    chk("rst_tohost_valid", tohost_valid, 0);
    chk("rst_tohost_data", tohost_data, 0);
    resetn = 1'b1;
    @(negedge clk);
    chk("post_rst_cmd_ready", cmd_ready, 1);
    chk("post_rst_resp_ready", pcr_resp_ready, 1);
    for (int i = 0; i < 9; i++)
      user_txn(tbl[i].rw, tbl[i].a, tbl[i].d, tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].err, tbl[i].edata, tbl[i].ek);
    pcr_resp_valid = 1'b1;
    pcr_resp_data = 64'hDEAD;
    chk("late_resp_ready", pcr_resp_ready, 1);
    chk("late_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    pcr_resp_valid = 1'b0;
    chk("late_no_result", res_valid, 0);
    chk("late_idle", busy, 0);
    for (int i = 0; i < 40; i++) begin
      rw = 1'($urandom_range(0, 1));
      a = 12'($urandom);
      d = {$urandom, $urandom};
      rdy = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 3, TMO + 2)) : int'($urandom_range(0, 5));
      rsp = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, TMO + 1)) : int'($urandom_range(1, 6));
      rdata = rw ? d ^ 64'h0F0F_0F0F_0F0F_0F0F : mem[a];
      ok = completes(rdy, rsp);
      user_txn(rw, a, d, rdy, rsp, rdata, !ok, ok ? rdata : 64'h0, ok ? rdy + rsp + 1 : TMO);
      if (ok && rw) mem[a] = d;
    end
    @(negedge clk);
    poll_en = 1'b1;
    serve("poll_a", 1'b0, 64'h0, 1'b0, 64'h0, PI + 4, w);
    chk("poll_a_interval", w, PI);
    serve("poll_b", 1'b0, 64'h0, 1'b0, 64'h1, PI + 4, w);
    chk("poll_b_interval", w, PI);
    serve("clear", 1'b1, 64'h0, 1'b1, 64'h0, 4, w);
    chk("tohost_valid", tohost_valid, 1);
    chk("tohost_data", tohost_data, 1);
    n = 0;
    repeat (2 * PI) begin
      @(negedge clk);
      n += int'(pcr_req_valid);
    end
    chk("poll_suspended", n, 0);
    user_txn(1'b1, 12'h042, 64'h55, 0, 1, 64'h66, 1'b0, 64'h66, 2);
    chk("tohost_still_valid", tohost_valid, 1);
    n = 0;
    repeat (PI + 2) begin
      @(negedge clk);
      n += int'(pcr_req_valid);
    end
    chk("poll_still_suspended", n, 0);
    tohost_ready = 1'b1;
    @(negedge clk);
    tohost_ready = 1'b0;
    chk("tohost_cleared", tohost_valid, 0);
    serve("poll_c", 1'b0, 64'h0, 1'b0, 64'h0, PI + 4, w);
    chk("poll_c_interval", w, PI);
    poll_en = 1'b0;
    @(negedge clk);
    poll_en = 1'b1;
    repeat (PI - 1) @(negedge clk);
    user_txn(1'b0, 12'h111, 64'h0, 0, 2, 64'hBEEF, 1'b0, 64'hBEEF, 3);
    serve("pend_poll", 1'b0, 64'h0, 1'b0, 64'h0, 3, w);
    poll_en = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_addr = 12'h321; cmd_data = 64'h9;
    @(negedge clk);
    cmd_valid = 1'b0;
    pcr_req_ready = 1'b1;
    @(negedge clk);
    pcr_req_ready = 1'b0;
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_resp_ready", pcr_resp_ready, 1);
    resetn = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_req_valid", pcr_req_valid, 0);
    chk("arst_req_addr", pcr_req_addr, 0);
    chk("arst_res_valid", res_valid, 0);
    chk("arst_res_data", res_data, 0);
    chk("arst_tohost_valid", tohost_valid, 0);
    chk("arst_tohost_data", tohost_data, 0);
    @(negedge clk);
    resetn = 1'b1;
    pcr_resp_valid = 1'b1;
    pcr_resp_data = 64'h77;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      n += int'(res_valid) + int'(busy);
    end
    pcr_resp_valid = 1'b0;
    chk("rst_abandoned", n, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
